// File: rtl/writeback.sv
// Y86-64 SEQ write-back stage: picks dstE/dstM from the instruction and
// registers the next register file, one flop bank per architectural register.

module writeback_reg #(
  parameter logic [3:0] IDX = 4'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  dst_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_e,
  input  logic [63:0] val_m,
  input  logic [63:0] r_cur,
  output logic [63:0] ro
);
  logic [63:0] ro_d, ro_q;

  // IDX never equals 0xF, so a "none" destination matches no bank.
  always_comb begin
    ro_d = r_cur;
    if (dst_m == IDX)      ro_d = val_m;
    else if (dst_e == IDX) ro_d = val_e;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ro_q <= '0;
    else        ro_q <= ro_d;
  end

  assign ro = ro_q;
endmodule

module writeback (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  icode,
  input  logic        Cnd,
  input  logic [63:0] valM,
  input  logic [63:0] valE,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic [63:0] R0,  R1,  R2,  R3,  R4,
  input  logic [63:0] R5,  R6,  R7,  R8,  R9,
  input  logic [63:0] R10, R11, R12, R13, R14,
  output logic [63:0] Ro0,  Ro1,  Ro2,  Ro3,  Ro4,
  output logic [63:0] Ro5,  Ro6,  Ro7,  Ro8,  Ro9,
  output logic [63:0] Ro10, Ro11, Ro12, Ro13, Ro14
);
  localparam int NUM_REGS = 15;
  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  logic [NUM_REGS-1:0][63:0] r_cur, ro;
  logic [3:0] dst_e, dst_m;

  assign r_cur = {R14, R13, R12, R11, R10, R9, R8, R7, R6, R5, R4, R3, R2, R1, R0};

  always_comb begin
    dst_e = RNONE;
    dst_m = RNONE;
    case (icode)
      4'h2:                   dst_e = Cnd ? rB : RNONE;
      4'h3, 4'h6:             dst_e = rB;
      4'h8, 4'h9, 4'hA, 4'hB: dst_e = RRSP;
      default:                dst_e = RNONE;
    endcase
    if (icode == 4'h5 || icode == 4'hB) dst_m = rA;
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    writeback_reg #(.IDX(4'(g))) u_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .dst_e (dst_e),
      .dst_m (dst_m),
      .val_e (valE),
      .val_m (valM),
      .r_cur (r_cur[g]),
      .ro    (ro[g])
    );
  end

  assign Ro0  = ro[0];
  assign Ro1  = ro[1];
  assign Ro2  = ro[2];
  assign Ro3  = ro[3];
  assign Ro4  = ro[4];
  assign Ro5  = ro[5];
  assign Ro6  = ro[6];
  assign Ro7  = ro[7];
  assign Ro8  = ro[8];
  assign Ro9  = ro[9];
  assign Ro10 = ro[10];
  assign Ro11 = ro[11];
  assign Ro12 = ro[12];
  assign Ro13 = ro[13];
  assign Ro14 = ro[14];
endmodule

// File: tb/tb_writeback.sv
// Directed bench for the write-back stage: a vector table run with R_i = i,
// plus hand sequences for async reset and between-edge output stability.

module tb_writeback;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  icode, rA, rB;
  logic        Cnd;
  logic [63:0] valM, valE;
  logic [63:0] r  [15];
  logic [63:0] ro [15];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  writeback dut (
    .clk(clk), .rst_n(rst_n), .icode(icode), .Cnd(Cnd),
    .valM(valM), .valE(valE), .rA(rA), .rB(rB),
    .R0(r[0]),   .R1(r[1]),   .R2(r[2]),   .R3(r[3]),   .R4(r[4]),
    .R5(r[5]),   .R6(r[6]),   .R7(r[7]),   .R8(r[8]),   .R9(r[9]),
    .R10(r[10]), .R11(r[11]), .R12(r[12]), .R13(r[13]), .R14(r[14]),
    .Ro0(ro[0]),   .Ro1(ro[1]),   .Ro2(ro[2]),   .Ro3(ro[3]),   .Ro4(ro[4]),
    .Ro5(ro[5]),   .Ro6(ro[6]),   .Ro7(ro[7]),   .Ro8(ro[8]),   .Ro9(ro[9]),
    .Ro10(ro[10]), .Ro11(ro[11]), .Ro12(ro[12]), .Ro13(ro[13]), .Ro14(ro[14])
  );

  typedef struct {
    string       name;
    logic [3:0]  icode;
    logic        cnd;
    logic [3:0]  ra, rb;
    logic [63:0] vale, valm;
    logic [3:0]  i1;   // registers expected to change (0xF = none)
    logic [63:0] v1;
    logic [3:0]  i2;
    logic [63:0] v2;
  } vec_t;

  vec_t vecs[$];
  logic [63:0] exp_r [15];

  function automatic vec_t mk(string n, logic [3:0] ic, logic c, logic [3:0] a, logic [3:0] b,
                              logic [63:0] e, logic [63:0] m,
                              logic [3:0] i1, logic [63:0] v1, logic [3:0] i2, logic [63:0] v2);
    vec_t v;
    v.name = n; v.icode = ic; v.cnd = c; v.ra = a; v.rb = b; v.vale = e; v.valm = m;
    v.i1 = i1; v.v1 = v1; v.i2 = i2; v.v2 = v2;
    return v;
  endfunction

  task automatic chk(input string n, input int idx, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s Ro%0d got=%h want=%h", n, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string n);
    for (int i = 0; i < 15; i++) chk(n, i, ro[i], exp_r[i]);
  endtask

  task automatic set_identity();
    for (int i = 0; i < 15; i++) r[i] = 64'(i);
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    icode = v.icode; Cnd = v.cnd; rA = v.ra; rB = v.rb; valE = v.vale; valM = v.valm;
    for (int i = 0; i < 15; i++) begin
      exp_r[i] = 64'(i);
      if (4'(i) == v.i1) exp_r[i] = v.v1;
      if (4'(i) == v.i2) exp_r[i] = v.v2;
    end
    @(posedge clk); #1;
    chk_all(v.name);
  endtask

  initial begin
    localparam logic [3:0] N = 4'hF;
    vecs.push_back(mk("opq",        4'h6, 0, 4'h0, 4'h1, 64'd19, 64'd0,  4'd1, 64'd19, N, 0));
    vecs.push_back(mk("call",       4'h8, 0, N,    N,    64'd19, 64'd0,  4'd4, 64'd19, N, 0));
    vecs.push_back(mk("popq",       4'hB, 0, 4'h0, N,    64'd19, 64'd13, 4'd0, 64'd13, 4'd4, 64'd19));
    vecs.push_back(mk("nop",        4'h1, 1, 4'h2, 4'h3, 64'd99, 64'd77, N, 0, N, 0));
    vecs.push_back(mk("mrmovq",     4'h5, 1, 4'h7, 4'h2, 64'd55, 64'd13, 4'd7, 64'd13, N, 0));
    vecs.push_back(mk("cmov_c0",    4'h2, 0, N,    4'h5, 64'd7,  64'd0,  N, 0, N, 0));
    vecs.push_back(mk("cmov_c1",    4'h2, 1, N,    4'h5, 64'd7,  64'd0,  4'd5, 64'd7, N, 0));
    vecs.push_back(mk("popq_rsp",   4'hB, 0, 4'h4, N,    64'd19, 64'd13, 4'd4, 64'd13, N, 0));
    vecs.push_back(mk("irmovq_f",   4'h3, 1, N,    N,    64'd19, 64'd13, N, 0, N, 0));
    vecs.push_back(mk("rmmovq",     4'h4, 1, 4'h3, 4'h2, 64'd19, 64'd13, N, 0, N, 0));
    vecs.push_back(mk("opq_r14",    4'h6, 0, 4'h1, 4'hE, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd14, 64'hFFFF_FFFF_FFFF_FFFF, N, 0));
    vecs.push_back(mk("undef_f",    4'hF, 1, 4'h0, 4'h1, 64'd19, 64'd13, N, 0, N, 0));
    vecs.push_back(mk("pushq",      4'hA, 0, 4'h3, N,    64'h100, 64'd5, 4'd4, 64'h100, N, 0));
    vecs.push_back(mk("ret",        4'h9, 1, N,    N,    64'h28, 64'h30, 4'd4, 64'h28, N, 0));
    vecs.push_back(mk("irmovq_r0",  4'h3, 0, N,    4'h0, 64'h8000_0000_0000_0001, 64'd2, 4'd0, 64'h8000_0000_0000_0001, N, 0));
    vecs.push_back(mk("halt",       4'h0, 1, 4'h1, 4'h2, 64'd19, 64'd13, N, 0, N, 0));
    vecs.push_back(mk("mrmovq_f",   4'h5, 0, N,    4'h3, 64'd19, 64'd13, N, 0, N, 0));
    vecs.push_back(mk("cmov_rb_f",  4'h2, 1, 4'h1, N,    64'd19, 64'd13, N, 0, N, 0));
    vecs.push_back(mk("undef_c",    4'hC, 1, 4'h5, 4'h6, 64'd19, 64'd13, N, 0, N, 0));

    // reset state
    rst_n = 1'b0; icode = 4'h1; Cnd = 0; rA = N; rB = N; valE = '0; valM = '0;
    for (int i = 0; i < 15; i++) r[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
    for (int i = 0; i < 15; i++) exp_r[i] = '0;
    #1 chk_all("reset_init");
    @(posedge clk); #1 chk_all("reset_hold");

    // first capture after release passes inputs through
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) exp_r[i] = r[i];
    chk_all("first_capture");

    // asynchronous reset mid-cycle, no clock edge involved
    @(negedge clk); #2; rst_n = 1'b0;
    for (int i = 0; i < 15; i++) exp_r[i] = '0;
    #1 chk_all("async_reset");
    @(posedge clk); #1 chk_all("reset_low_clk");
    @(negedge clk); rst_n = 1'b1;
    set_identity();

    foreach (vecs[k]) run_vec(vecs[k]);

    // outputs hold between edges even when inputs move
    @(negedge clk);
    icode = 4'h6; rB = 4'h2; valE = 64'hDEAD_BEEF; valM = 64'd1; r[9] = 64'h99;
    #3 chk_all("stable_mid");
    @(posedge clk); #1;
    for (int i = 0; i < 15; i++) exp_r[i] = 64'(i);
    exp_r[2] = 64'hDEAD_BEEF; exp_r[9] = 64'h99;
    chk_all("after_edge");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
